// File: rtl/handover_if.sv
// Handover link bundle: request, ack-token and consumer-side signals.
// The master modport is the initiator/consumer side; slave is the responder.
interface handover_if #(
    parameter int DW = 8,
    parameter int CW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_seq;
    logic [DW-1:0] req_data;
    logic          ack_valid;
    logic          ack_ready;
    logic [CW-1:0] ack_seq;
    logic          ack_ok;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] rx_count;
    logic [7:0]    err_count;

    modport slave (
        input  req_valid, req_seq, req_data, ack_ready, out_ready,
        output req_ready, ack_valid, ack_seq, ack_ok,
        output out_valid, out_data, rx_count, err_count
    );

    modport master (
        output req_valid, req_seq, req_data, ack_ready, out_ready,
        input  req_ready, ack_valid, ack_seq, ack_ok,
        input  out_valid, out_data, rx_count, err_count
    );
endinterface

// File: rtl/handover_responder.sv
// Receiving end of the handover link: sequence check, payload FIFO,
// and a single registered ack slot returned to the initiator.
module handover_responder #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    handover_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, PEND} ack_st_e;

    ack_st_e       state_q, state_d;
    logic [CW-1:0] ack_seq_q, ack_seq_d;
    logic          ack_ok_q, ack_ok_d;
    logic [CW-1:0] rx_q, rx_d;
    logic [7:0]    err_q, err_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic full, empty, accept, in_order, push, pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    // A new request may only be taken if its ack can land in the slot.
    assign bus.req_ready = !rst && !full &&
                           (state_q == IDLE || bus.ack_ready);
    assign accept   = bus.req_valid && bus.req_ready;
    assign in_order = (bus.req_seq == rx_q);
    assign push     = accept && in_order;
    assign pop      = bus.out_ready && !empty;

    always_comb begin
        state_d   = state_q;
        ack_seq_d = ack_seq_q;
        ack_ok_d  = ack_ok_q;
        rx_d      = rx_q;
        err_d     = err_q;
        if (accept) begin
            state_d   = PEND;
            ack_seq_d = bus.req_seq;
            ack_ok_d  = in_order;
            if (in_order) begin
                rx_d = rx_q + CW'(1);
            end else if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end else if (state_q == PEND && bus.ack_ready) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + AW'(1);
        if (pop)  rd_d = rd_q + AW'(1);
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ack_seq_q <= '0;
            ack_ok_q  <= 1'b0;
            rx_q      <= '0;
            err_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_seq_q <= ack_seq_d;
            ack_ok_q  <= ack_ok_d;
            rx_q      <= rx_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.req_data;
    end

    assign bus.ack_valid = (state_q == PEND);
    assign bus.ack_seq   = ack_seq_q;
    assign bus.ack_ok    = ack_ok_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_q];
    assign bus.rx_count  = rx_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_handover_responder.sv
// Bench for handover_responder: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_handover_responder;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    handover_if #(.DW(DW), .CW(CW)) bus ();

    handover_responder #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int npass = 0;
    int ntot  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] mrx  = 8'd0;
    logic [7:0] merr = 8'd0;
    bit         mav  = 1'b0;
    logic [7:0] mseq = 8'd0;
    bit         mok  = 1'b0;
    bit         started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            npass++;
    endtask

    function automatic bit model_ready();
        return !rst && (mq.size() < DEPTH) && (!mav || bus.ack_ready);
    endfunction

    // Model advances on each rising edge from the inputs held during the cycle
    always @(posedge clk) begin
        bit acc, good, popm;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            mrx  = 8'd0;
            merr = 8'd0;
            mav  = 1'b0;
            mseq = 8'd0;
            mok  = 1'b0;
        end else begin
            acc  = bus.req_valid && model_ready();
            good = acc && (bus.req_seq == mrx);
            popm = bus.out_ready && (mq.size() > 0);
            if (popm) void'(mq.pop_front());
            if (acc) begin
                mav  = 1'b1;
                mseq = bus.req_seq;
                mok  = good;
                if (good) begin
                    mq.push_back(bus.req_data);
                    mrx = mrx + 8'd1;
                end else if (merr != 8'd255) begin
                    merr = merr + 8'd1;
                end
            end else if (mav && bus.ack_ready) begin
                mav = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", bus.req_ready, model_ready());
            chk("ack_valid", bus.ack_valid, mav);
            if (mav) begin
                chk("ack_seq", bus.ack_seq, mseq);
                chk("ack_ok", bus.ack_ok, mok);
            end
            chk("out_valid", bus.out_valid, mq.size() > 0);
            if (mq.size() > 0) chk("out_data", bus.out_data, mq[0]);
            chk("rx_count", bus.rx_count, mrx);
            chk("err_count", bus.err_count, merr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input logic [7:0] d);
        int n;
        bus.req_valid = 1'b1;
        bus.req_seq   = s;
        bus.req_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        cyc();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_seq   = '0;
        bus.req_data  = '0;
        bus.ack_ready = 1'b1;
        bus.out_ready = 1'b0;

        // Reset
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_ack_valid", bus.ack_valid, 0);
        chk("rst_ack_seq", bus.ack_seq, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_rx", bus.rx_count, 0);
        chk("rst_err", bus.err_count, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", bus.req_ready, 1);
        cyc();

        // In-order stream
        send(8'd0, 8'hA1);
        send(8'd1, 8'hB2);
        send(8'd2, 8'hC3);
        @(negedge clk);
        chk("io_ack_valid", bus.ack_valid, 1);
        chk("io_ack_seq", bus.ack_seq, 2);
        chk("io_ack_ok", bus.ack_ok, 1);
        chk("io_rx", bus.rx_count, 3);
        chk("io_head", bus.out_data, 8'hA1);
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("io_pop0", bus.out_data, 8'hA1);
        @(negedge clk);
        chk("io_pop1", bus.out_data, 8'hB2);
        @(negedge clk);
        chk("io_pop2", bus.out_data, 8'hC3);
        cyc();
        bus.out_ready = 1'b0;

        // Sequence mismatch then recovery
        send(8'd5, 8'h55);
        @(negedge clk);
        chk("mm_ack_ok", bus.ack_ok, 0);
        chk("mm_ack_seq", bus.ack_seq, 5);
        chk("mm_err", bus.err_count, 1);
        chk("mm_rx", bus.rx_count, 3);
        chk("mm_out_valid", bus.out_valid, 0);
        cyc();
        send(8'd3, 8'h33);
        @(negedge clk);
        chk("rc_ack_ok", bus.ack_ok, 1);
        chk("rc_rx", bus.rx_count, 4);
        chk("rc_head", bus.out_data, 8'h33);
        cyc();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // Backpressure until full, no bypass when full
        send(8'd4, 8'h44);
        send(8'd5, 8'h45);
        send(8'd6, 8'h46);
        send(8'd7, 8'h47);
        @(negedge clk);
        chk("full_req_ready", bus.req_ready, 0);
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_nobypass", bus.req_ready, 0);
        cyc();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_ready", bus.req_ready, 1);
        cyc();
        bus.out_ready = 1'b1;
        repeat (4) cyc();

        // Ack stall
        bus.ack_ready = 1'b0;
        send(8'd8, 8'h88);
        @(negedge clk);
        chk("stall_ready", bus.req_ready, 0);
        chk("stall_ack_valid", bus.ack_valid, 1);
        repeat (2) cyc();
        @(negedge clk);
        chk("stall_held_seq", bus.ack_seq, 8);
        cyc();
        bus.ack_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ready", bus.req_ready, 1);
        cyc();
        send(8'd9, 8'h99);
        @(negedge clk);
        chk("unstall_rx", bus.rx_count, 10);
        cyc();

        // Sequence wrap and error saturation
        while (mrx != 8'd255) send(mrx, mrx ^ 8'h5A);
        send(8'd255, 8'hEE);
        @(negedge clk);
        chk("wrap_rx", bus.rx_count, 0);
        cyc();
        for (int i = 0; i < 256; i++) send(8'd7, i[7:0]);
        @(negedge clk);
        chk("sat_err", bus.err_count, 255);
        chk("sat_rx", bus.rx_count, 0);
        cyc();

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_seq   = ($urandom_range(0, 1) == 0) ? mrx :
                            8'($urandom_range(0, 255));
            bus.req_data  = 8'($urandom_range(0, 255));
            bus.ack_ready = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        cyc();
        @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
